// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port register file with an integrated busy-bit scoreboard.
// Sits between decode (reads, reserve) and writeback (two write ports).
//
// Parameters: DATA_W register width, ADDR_W address width (depth 2**ADDR_W),
//             NUM_RD number of combinational read ports (1..4).
// Ports:
//   clock, reset        posedge clock, asynchronous active-low reset
//   read_addr/data/busy NUM_RD packed read ports, combinational
//   wr0_*               write port 0 (ALU writeback)
//   wr1_*               write port 1 (memory writeback), wins over wr0
//   rsv_en/rsv_addr     reserve a destination (set its busy bit)
//   busy_any            OR of all busy bits
// Optional macro REG_FILE_MP_BYPASS_EN: same-cycle write-to-read forwarding.
module reg_file_mp #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_RD*ADDR_W-1:0] read_addr,
    output logic [NUM_RD*DATA_W-1:0] read_data,
    output logic [NUM_RD-1:0]        read_busy,
    input  logic                     wr0_en,
    input  logic [ADDR_W-1:0]        wr0_addr,
    input  logic [DATA_W-1:0]        wr0_data,
    input  logic                     wr1_en,
    input  logic [ADDR_W-1:0]        wr1_addr,
    input  logic [DATA_W-1:0]        wr1_data,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    output logic                     busy_any
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;

    // One-hot decodes; bit 0 stays low so r0 is never written or reserved.
    logic [DEPTH-1:0] wr0_hit;
    logic [DEPTH-1:0] wr1_hit;
    logic [DEPTH-1:0] rsv_hit;

    always_comb begin
        wr0_hit = '0;
        wr1_hit = '0;
        rsv_hit = '0;
        for (int a = 1; a < DEPTH; a++) begin
            wr0_hit[a] = wr0_en && (wr0_addr == ADDR_W'(a));
            wr1_hit[a] = wr1_en && (wr1_addr == ADDR_W'(a));
            rsv_hit[a] = rsv_en && (rsv_addr == ADDR_W'(a));
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy <= '0;
            for (int a = 0; a < DEPTH; a++) begin
                regs[a] <= '0;
            end
        end else begin
            for (int a = 0; a < DEPTH; a++) begin
                if (wr1_hit[a]) begin
                    regs[a] <= wr1_data;
                end else if (wr0_hit[a]) begin
                    regs[a] <= wr0_data;
                end
                // A new reservation outranks the retiring producer.
                if (rsv_hit[a]) begin
                    busy[a] <= 1'b1;
                end else if (wr0_hit[a] || wr1_hit[a]) begin
                    busy[a] <= 1'b0;
                end
            end
        end
    end

    assign busy_any = |busy;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] stored;

        assign ra     = read_addr[k*ADDR_W +: ADDR_W];
        assign stored = (ra == '0) ? '0 : regs[ra];

`ifdef REG_FILE_MP_BYPASS_EN
        // Hit vectors already exclude r0, so r0 is never forwarded.
        assign read_data[k*DATA_W +: DATA_W] =
            wr1_hit[ra] ? wr1_data :
            wr0_hit[ra] ? wr0_data : stored;
        assign read_busy[k] =
            (wr1_hit[ra] || wr0_hit[ra]) ? rsv_hit[ra] : busy[ra];
`else
        assign read_data[k*DATA_W +: DATA_W] = stored;
        assign read_busy[k]                  = busy[ra];
`endif
    end

endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: directed plan checks plus randomized traffic against
// an array-based reference model; a second small-parameter instance.
module tb_reg_file_mp;

    logic        clock;
    logic        reset;
    logic [9:0]  read_addr;
    logic [63:0] read_data;
    logic [1:0]  read_busy;
    logic        wr0_en, wr1_en, rsv_en;
    logic [4:0]  wr0_addr, wr1_addr, rsv_addr;
    logic [31:0] wr0_data, wr1_data;
    logic        busy_any;

    logic [11:0] s_read_addr;
    logic [63:0] s_read_data;
    logic [3:0]  s_read_busy;
    logic        s_wr0_en, s_wr1_en, s_rsv_en;
    logic [2:0]  s_wr0_addr, s_wr1_addr, s_rsv_addr;
    logic [15:0] s_wr0_data, s_wr1_data;
    logic        s_busy_any;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] m_reg  [32];
    logic        m_busy [32];

    reg_file_mp u_dut (
        .clock     (clock),
        .reset     (reset),
        .read_addr (read_addr),
        .read_data (read_data),
        .read_busy (read_busy),
        .wr0_en    (wr0_en),
        .wr0_addr  (wr0_addr),
        .wr0_data  (wr0_data),
        .wr1_en    (wr1_en),
        .wr1_addr  (wr1_addr),
        .wr1_data  (wr1_data),
        .rsv_en    (rsv_en),
        .rsv_addr  (rsv_addr),
        .busy_any  (busy_any)
    );

    reg_file_mp #(.DATA_W(16), .ADDR_W(3), .NUM_RD(4)) u_small (
        .clock     (clock),
        .reset     (reset),
        .read_addr (s_read_addr),
        .read_data (s_read_data),
        .read_busy (s_read_busy),
        .wr0_en    (s_wr0_en),
        .wr0_addr  (s_wr0_addr),
        .wr0_data  (s_wr0_data),
        .wr1_en    (s_wr1_en),
        .wr1_addr  (s_wr1_addr),
        .wr1_data  (s_wr1_data),
        .rsv_en    (s_rsv_en),
        .rsv_addr  (s_rsv_addr),
        .busy_any  (s_busy_any)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 0) return 32'h0;
`ifdef REG_FILE_MP_BYPASS_EN
        if (wr1_en && wr1_addr == a) return wr1_data;
        if (wr0_en && wr0_addr == a) return wr0_data;
`endif
        return m_reg[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        if (a == 0) return 1'b0;
`ifdef REG_FILE_MP_BYPASS_EN
        if ((wr1_en && wr1_addr == a) || (wr0_en && wr0_addr == a))
            return rsv_en && rsv_addr == a;
`endif
        return m_busy[a];
    endfunction

    function automatic logic model_any();
        logic r = 1'b0;
        for (int i = 0; i < 32; i++) r |= m_busy[i];
        return r;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            m_reg[i]  = 32'h0;
            m_busy[i] = 1'b0;
        end
    endtask

    // Register writes: wr1 applied last so it overrides wr0.
    // Busy: writes clear first, then a reservation sets.
    task automatic model_update();
        if (wr0_en && wr0_addr != 0) begin
            m_reg[wr0_addr]  = wr0_data;
            m_busy[wr0_addr] = 1'b0;
        end
        if (wr1_en && wr1_addr != 0) begin
            m_reg[wr1_addr]  = wr1_data;
            m_busy[wr1_addr] = 1'b0;
        end
        if (rsv_en && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
    endtask

    task automatic check_reads();
        for (int k = 0; k < 2; k++) begin
            logic [4:0] a;
            a = read_addr[k*5 +: 5];
            check($sformatf("rd%0d_r%0d", k, a),
                  64'(read_data[k*32 +: 32]), 64'(exp_rd(a)));
            check($sformatf("busy%0d_r%0d", k, a),
                  64'(read_busy[k]), 64'(exp_busy(a)));
        end
        check("busy_any", 64'(busy_any), 64'(model_any()));
    endtask

    // Entered at a negedge with inputs set; leaves at the next negedge.
    task automatic step();
        #1 check_reads();
        @(posedge clock);
        model_update();
        @(negedge clock);
    endtask

    task automatic idle();
        wr0_en = 0; wr1_en = 0; rsv_en = 0;
        wr0_addr = 0; wr1_addr = 0; rsv_addr = 0;
        wr0_data = 0; wr1_data = 0;
    endtask

    task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
        read_addr = {a1, a0};
    endtask

    initial begin
        reset = 1'b0;
        idle();
        rd(0, 5);
        s_read_addr = '0;
        s_wr0_en = 0; s_wr1_en = 0; s_rsv_en = 0;
        s_wr0_addr = 0; s_wr1_addr = 0; s_rsv_addr = 0;
        s_wr0_data = 0; s_wr1_data = 0;
        model_clear();
        @(negedge clock);
        #1 check("rst_rd", 64'(read_data), 64'h0);
        check("rst_any", 64'(busy_any), 64'h0);
        @(negedge clock);
        reset = 1'b1;

        // Write r5, then an asynchronous reset pulse between edges.
        wr0_en = 1; wr0_addr = 5; wr0_data = 32'hDEADBEEF;
        rsv_en = 1; rsv_addr = 6;
        step();
        idle(); rd(5, 6);
        step();
        check("r5_pre", 64'(read_data[31:0]), 64'hDEADBEEF);
        #2 reset = 1'b0;
        #1 check("r5_async_rst", 64'(read_data[31:0]), 64'h0);
        check("any_async_rst", 64'(busy_any), 64'h0);
        model_clear();
        @(negedge clock);
        reset = 1'b1;

        // r0 is never written nor reserved.
        wr0_en = 1; wr0_addr = 0; wr0_data = 32'h12345678;
        rsv_en = 1; rsv_addr = 0; rd(0, 0);
        step();
        idle();
        #1 check("r0_data", 64'(read_data), 64'h0);
        check("r0_busy", 64'(read_busy), 64'h0);
        step();

        wr0_en = 1; wr0_addr = 1; wr0_data = 32'hA5A5A5A5; rd(1, 1);
        step();
        idle();
        #1 check("r1_data", 64'(read_data[63:32]), 64'hA5A5A5A5);
        step();

        // Same-address conflict, then two different addresses.
        wr0_en = 1; wr0_addr = 7; wr0_data = 32'h11111111;
        wr1_en = 1; wr1_addr = 7; wr1_data = 32'h22222222; rd(7, 0);
        step();
        wr0_addr = 8; wr0_data = 32'h3;
        wr1_addr = 9; wr1_data = 32'h4;
        #1 check("r7_wr1_wins", 64'(read_data[31:0]), 64'h22222222);
        step();
        idle(); rd(8, 9);
        #1 check("r8_r9", 64'(read_data), {32'h4, 32'h3});
        step();

        // Scoreboard: reserve, clear on write, reserve+write together.
        rsv_en = 1; rsv_addr = 3; rd(3, 3);
        step();
        idle();
        #1 check("r3_rsv", 64'(read_busy), 64'h3);
        step();
        wr0_en = 1; wr0_addr = 3; wr0_data = 32'h55;
        step();
        idle();
        #1 check("r3_clr", 64'(read_busy), 64'h0);
        step();
        rsv_en = 1; rsv_addr = 3;
        wr1_en = 1; wr1_addr = 3; wr1_data = 32'h66;
        step();
        idle();
        #1 check("r3_rsv_wr", 64'({read_busy, read_data[31:0]}),
                 {30'h0, 2'b11, 32'h66});
        step();

        // Forwarding while r4 is busy.
        wr0_en = 1; wr0_addr = 4; wr0_data = 32'h44;
        step();
        idle(); rsv_en = 1; rsv_addr = 4;
        step();
        idle(); rd(4, 4);
        wr0_en = 1; wr0_addr = 4; wr0_data = 32'h77;
`ifdef REG_FILE_MP_BYPASS_EN
        #1 check("byp_data", 64'(read_data), {32'h77, 32'h77});
        check("byp_busy", 64'(read_busy), 64'h0);
`else
        #1 check("nobyp_data", 64'(read_data), {32'h44, 32'h44});
        check("nobyp_busy", 64'(read_busy), 64'h3);
`endif
        step();
        idle();

        // Small configuration: 16-bit, 8 deep, four read ports.
        s_wr0_en = 1; s_wr0_addr = 7; s_wr0_data = 16'hBEEF;
        s_read_addr = {3'd7, 3'd7, 3'd7, 3'd0};
        @(negedge clock);
        s_wr0_en = 0;
        s_read_addr = {3'd7, 3'd7, 3'd7, 3'd7};
        #1;
        for (int k = 0; k < 4; k++)
            check($sformatf("small_rd%0d", k),
                  64'(s_read_data[k*16 +: 16]), 64'hBEEF);
        s_read_addr = '0;
        #1 check("small_r0", 64'(s_read_data[15:0]), 64'h0);
        @(negedge clock);

        // Randomized traffic, addresses biased toward collisions.
        for (int i = 0; i < 400; i++) begin
            wr0_en   = 1'($urandom);
            wr1_en   = 1'($urandom);
            rsv_en   = ($urandom_range(0, 2) == 0);
            wr0_addr = 5'($urandom_range(0, 7));
            wr1_addr = 5'($urandom_range(0, 7));
            rsv_addr = 5'($urandom_range(0, 7));
            wr0_data = $urandom;
            wr1_data = $urandom;
            if ($urandom_range(0, 3) == 0)
                rd(5'($urandom), 5'($urandom));
            else
                rd(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            step();
        end
        idle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
